// File: rtl/key_led_ctrl_if.sv
// Key/LED channel bundle: raw active-low keys and clear in, press pulses,
// per-channel mode and LED drive out.
interface key_led_ctrl_if #(
  parameter int N_KEY = 4
);
  logic [N_KEY-1:0]   key;
  logic               clr;
  logic [N_KEY-1:0]   press;
  logic [2*N_KEY-1:0] mode;
  logic [N_KEY-1:0]   led;

  modport master (
    output key,
    output clr,
    input  press,
    input  mode,
    input  led
  );

  modport slave (
    input  key,
    input  clr,
    output press,
    output mode,
    output led
  );
endinterface

// File: rtl/key_led_ctrl.sv
// Multi-key debounce and LED mode controller: each debounced press steps its
// LED through OFF -> ON -> BLINK -> OFF; one shared blink timer keeps BLINK in phase.
module key_led_ctrl #(
  parameter int N_KEY     = 4,
  parameter int DEB_CYC   = 1_000_000,
  parameter int BLINK_CYC = 25_000_000
) (
  input  logic           clk,
  input  logic           rstn,
  key_led_ctrl_if.slave  bus
);

  localparam int CNT_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int BCNT_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEB_CYC - 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10
  } mode_e;

  // Two-flop synchroniser; idle (released) level is high.
  logic [N_KEY-1:0] key_s1_q, key_s1_d;
  logic [N_KEY-1:0] key_s2_q, key_s2_d;

  always_comb begin
    key_s1_d = bus.key;
    key_s2_d = key_s1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_s1_q <= '1;
      key_s2_q <= '1;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
    end
  end

  // Free-running blink timer shared by all channels; clr leaves it alone.
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q + BCNT_W'(1);
    phase_d = phase_q;
    if (bcnt_q == BCNT_MAX) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  for (genvar gi = 0; gi < N_KEY; gi++) begin : g_ch
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    mode_e            mode_q, mode_d;
    logic             led_c;

    // Any return to the accepted level restarts the hold count.
    always_comb begin
      deb_d   = deb_q;
      cnt_d   = cnt_q + CNT_W'(1);
      press_d = 1'b0;
      if (key_s2_q[gi] == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_d   = key_s2_q[gi];
        cnt_d   = '0;
        press_d = deb_q;
      end
    end

    always_comb begin
      mode_d = mode_q;
      if (bus.clr) begin
        mode_d = MODE_OFF;
      end else if (press_q) begin
        case (mode_q)
          MODE_OFF: mode_d = MODE_ON;
          MODE_ON:  mode_d = MODE_BLINK;
          default:  mode_d = MODE_OFF;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        deb_q   <= 1'b1;
        cnt_q   <= '0;
        press_q <= 1'b0;
        mode_q  <= MODE_OFF;
      end else begin
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
        mode_q  <= mode_d;
      end
    end

    always_comb begin
      led_c = 1'b0;
      case (mode_q)
        MODE_ON:    led_c = 1'b1;
        MODE_BLINK: led_c = phase_q;
        default:    led_c = 1'b0;
      endcase
    end

    assign bus.press[gi]      = press_q;
    assign bus.mode[2*gi +: 2] = mode_q;
    assign bus.led[gi]        = led_c;
  end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Randomised and directed bench for key_led_ctrl against a window-based
// behavioural model of debounce, mode stepping and blink phase.
module tb_key_led_ctrl;
  localparam int NK  = 4;
  localparam int DEB = 8;
  localparam int BLK = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  key_led_ctrl_if #(.N_KEY(NK)) bus ();

  key_led_ctrl #(
    .N_KEY(NK),
    .DEB_CYC(DEB),
    .BLINK_CYC(BLK)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: raw key history per edge since reset release, accepted levels,
  // press pulses and mode as a count modulo 3.
  logic [NK-1:0] hist[$];
  int            t;
  logic [NK-1:0] m_deb;
  logic [NK-1:0] m_press;
  int            m_mode[NK];

  logic [15:0] dut_out;
  assign dut_out = {bus.press, bus.mode, bus.led};

  function automatic logic [NK-1:0] raw(int e);
    if (e >= 1) return hist[e-1];
    return '1;
  endfunction

  function automatic logic [15:0] exp_out();
    logic [7:0]    m;
    logic [NK-1:0] l;
    int            ph;
    ph = (t / BLK) % 2;
    for (int i = 0; i < NK; i++) begin
      m[2*i +: 2] = 2'(m_mode[i]);
      l[i] = (m_mode[i] == 1) || (m_mode[i] == 2 && ph == 1);
    end
    return {m_press, m, l};
  endfunction

  task automatic model_reset();
    hist.delete();
    t = 0;
    m_deb = '1;
    m_press = '0;
    for (int i = 0; i < NK; i++) m_mode[i] = 0;
  endtask

  task automatic model_edge();
    if (rstn !== 1'b1) return;
    t++;
    hist.push_back(bus.key);
    for (int i = 0; i < NK; i++) begin
      if (bus.clr) m_mode[i] = 0;
      else if (m_press[i]) m_mode[i] = (m_mode[i] + 1) % 3;
    end
    // A level is accepted once synchronised samples on the last DEB edges all differ.
    for (int i = 0; i < NK; i++) begin
      logic settle;
      logic [NK-1:0] r;
      settle = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        r = raw(t - 2 - j);
        if (r[i] == m_deb[i]) settle = 1'b0;
      end
      m_press[i] = 1'b0;
      if (settle) begin
        m_press[i] = m_deb[i];
        m_deb[i] = ~m_deb[i];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    bus.key = '1;
    bus.clr = 1'b0;
    rstn = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (dut_out !== 16'h0) begin
        n_bad++;
        $display("FAIL reset_state: got %h expected 0000", dut_out);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++;
        $display("FAIL reset_idle c=%0d: got %h expected %h", c, dut_out, exp_out());
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    int press_at, n_press;
    press_at = 0;
    n_press = 0;
    reset_dut();
    bus.key = 4'b1110;
    for (int c = 1; c <= 40; c++) begin
      if (c == 21) bus.key = 4'b1111;
      step();
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++;
        $display("FAIL single_model c=%0d: got %h expected %h", c, dut_out, exp_out());
      end
      if (bus.press != 4'b0000) begin
        n_press++;
        if (press_at == 0) press_at = c;
      end
    end
    n_cmp++;
    if (n_press !== 1 || press_at !== 10) begin
      n_bad++;
      $display("FAIL single_pulse: got count=%0d at=%0d expected count=1 at=10", n_press, press_at);
    end
    n_cmp++;
    if (bus.mode[1:0] !== 2'b01 || bus.led[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL single_mode: got mode=%b led=%b expected mode=01 led=1", bus.mode[1:0], bus.led[0]);
    end
    $display("test_single_press done: at=%0d", press_at);
  endtask

  task automatic test_bounce();
    int n_press;
    n_press = 0;
    reset_dut();
    for (int c = 1; c <= 35; c++) begin
      bus.key = ((c <= 7) || (c >= 9 && c <= 15)) ? 4'b1101 : 4'b1111;
      step();
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++;
        $display("FAIL bounce_model c=%0d: got %h expected %h", c, dut_out, exp_out());
      end
      if (bus.press != 4'b0000) n_press++;
    end
    n_cmp++;
    if (n_press !== 0 || bus.mode !== 8'h00) begin
      n_bad++;
      $display("FAIL bounce_reject: got presses=%0d mode=%h expected presses=0 mode=00", n_press, bus.mode);
    end
    $display("test_bounce done");
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_m[3];
    int         rel_len;
    exp_m[0] = 2'b01;
    exp_m[1] = 2'b10;
    exp_m[2] = 2'b00;
    reset_dut();
    for (int p = 0; p < 3; p++) begin
      bus.key = 4'b1011;
      for (int c = 0; c < 12; c++) begin
        step();
        n_cmp++;
        if (dut_out !== exp_out()) begin
          n_bad++;
          $display("FAIL cycle_model p=%0d c=%0d: got %h expected %h", p, c, dut_out, exp_out());
        end
      end
      n_cmp++;
      if (bus.mode[5:4] !== exp_m[p]) begin
        n_bad++;
        $display("FAIL cycle_mode p=%0d: got %b expected %b", p, bus.mode[5:4], exp_m[p]);
      end
      bus.key = 4'b1111;
      rel_len = (p == 1) ? 48 : 12;
      for (int c = 0; c < rel_len; c++) begin
        step();
        n_cmp++;
        if (dut_out !== exp_out()) begin
          n_bad++;
          $display("FAIL cycle_release p=%0d c=%0d: got %h expected %h", p, c, dut_out, exp_out());
        end
      end
    end
    $display("test_mode_cycle done");
  endtask

  task automatic test_simultaneous();
    int n_all, at;
    n_all = 0;
    at = 0;
    reset_dut();
    bus.key = 4'b0000;
    for (int c = 1; c <= 24; c++) begin
      if (c == 13) bus.key = 4'b1111;
      step();
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++;
        $display("FAIL simul_model c=%0d: got %h expected %h", c, dut_out, exp_out());
      end
      if (bus.press == 4'b1111) begin
        n_all++;
        at = c;
      end
      if (c == 12) begin
        n_cmp++;
        if (bus.mode !== 8'h55) begin
          n_bad++;
          $display("FAIL simul_mode: got %h expected 55", bus.mode);
        end
      end
    end
    n_cmp++;
    if (n_all !== 1 || at !== 10) begin
      n_bad++;
      $display("FAIL simul_pulse: got count=%0d at=%0d expected count=1 at=10", n_all, at);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_clr_priority();
    reset_dut();
    bus.key = 4'b0000;
    for (int c = 0; c < 12; c++) step();
    bus.key = 4'b1111;
    for (int c = 0; c < 12; c++) step();
    bus.key = 4'b0111;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++;
        $display("FAIL clr_model c=%0d: got %h expected %h", c, dut_out, exp_out());
      end
    end
    n_cmp++;
    if (bus.press !== 4'b1000 || bus.mode !== 8'h55) begin
      n_bad++;
      $display("FAIL clr_setup: got press=%b mode=%h expected press=1000 mode=55", bus.press, bus.mode);
    end
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    n_cmp++;
    if (bus.mode !== 8'h00 || bus.led !== 4'b0000) begin
      n_bad++;
      $display("FAIL clr_priority: got mode=%h led=%b expected mode=00 led=0000", bus.mode, bus.led);
    end
    bus.key = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      step();
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++;
        $display("FAIL clr_after c=%0d: got %h expected %h", c, dut_out, exp_out());
      end
    end
    $display("test_clr_priority done");
  endtask

  task automatic test_reset_mid();
    int at;
    at = 0;
    reset_dut();
    bus.key = 4'b0000;
    for (int c = 0; c < 12; c++) step();
    bus.key = 4'b1111;
    for (int c = 0; c < 12; c++) step();
    bus.key = 4'b1110;
    for (int c = 0; c < 7; c++) step();
    rstn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_out !== 16'h0) begin
      n_bad++;
      $display("FAIL midreset_immediate: got %h expected 0000", dut_out);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (dut_out !== 16'h0) begin
        n_bad++;
        $display("FAIL midreset_hold: got %h expected 0000", dut_out);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++;
        $display("FAIL midreset_model c=%0d: got %h expected %h", c, dut_out, exp_out());
      end
      if (bus.press[0] && at == 0) at = c;
    end
    n_cmp++;
    if (at !== 10) begin
      n_bad++;
      $display("FAIL midreset_latency: got %0d expected 10", at);
    end
    bus.key = 4'b1111;
    for (int c = 0; c < 12; c++) step();
    $display("test_reset_mid done: at=%0d", at);
  endtask

  task automatic test_random();
    int hold[NK];
    reset_dut();
    for (int i = 0; i < NK; i++) hold[i] = $urandom_range(1, 20);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NK; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          bus.key[i] = ~bus.key[i];
          hold[i] = $urandom_range(1, 20);
        end
      end
      bus.clr = ($urandom_range(0, 59) == 0);
      step();
      n_cmp++;
      if (dut_out !== exp_out()) begin
        n_bad++;
        $display("FAIL random c=%0d: got %h expected %h", c, dut_out, exp_out());
      end
    end
    bus.clr = 1'b0;
    bus.key = '1;
    $display("test_random done");
  endtask

  initial begin
    bus.key = '1;
    bus.clr = 1'b0;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_mode_cycle();
    test_simultaneous();
    test_clr_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
